fft3_frame_ctrl: RTL and testbench
==================================

FFT3_FRAME_CTRL -- requirements
Module: fft3_frame_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 18, sample component width.
REQ-002 SHALL have parameter MAX_STAGES, default 5, largest radix-3 stage count (N max = 3^MAX_STAGES).
REQ-003 SHALL have parameter SW, default 3, stage-field width, >= clog2(MAX_STAGES+1).
REQ-004 SHALL have one clock and an asynchronous active-high reset: clk input 1, master clock; rst input 1, asynchronous active-high reset.
REQ-005 cfg_valid input 1: stage-count request valid. cfg_ready output 1: request accepted this cycle when high with cfg_valid. cfg_stages input SW: requested stage count.
REQ-006 di_en input 1, di_re input WIDTH, di_im input WIDTH: source samples.
REQ-007 core_en output 1, core_re output WIDTH, core_im output WIDTH: samples to FFT core. core_stages output SW: latched stage count for the core.
REQ-008 cd_en input 1, cd_re input WIDTH, cd_im input WIDTH: core output samples.
REQ-009 do_en output 1, do_re output WIDTH, do_im output WIDTH, do_last output 1: frame output to downstream.
REQ-010 busy output 1; err_cfg output 1 (pulse); drop output 1 (pulse).

Function
REQ-011 SHALL implement states IDLE, LOAD, DRAIN; N = 3^core_stages.
REQ-012 IDLE: cfg_ready=1; cfg_valid with cfg_stages in 1..MAX_STAGES -> latch core_stages, clear counters, go LOAD next cycle.
REQ-013 IDLE: cfg_valid with cfg_stages 0 or > MAX_STAGES -> err_cfg high one cycle, core_stages unchanged, stay IDLE.
REQ-014 cfg_ready SHALL be 0 in LOAD and DRAIN; cfg_valid there is ignored, no error.
REQ-015 LOAD: each di_en forwarded to core_en/re/im with exactly 1 cycle latency; input counter increments; on the N-th sample go DRAIN.
REQ-016 di_en in IDLE or DRAIN (including the cfg-accept cycle) SHALL be dropped: core_en stays 0, drop high one cycle.
REQ-017 core_re/core_im SHALL hold last forwarded value when core_en=0.
REQ-018 cd_en in LOAD or DRAIN forwarded to do_en/re/im with 1 cycle latency; output counter increments; do_last high with the N-th output sample.
REQ-019 After the N-th output sample: go IDLE same cycle do_last asserts; further cd_en in IDLE discarded without drop pulse.
REQ-020 cd_en arriving while still in LOAD SHALL be counted (core latency may be shorter than frame).
REQ-021 core_stages SHALL be stable from accept until return to IDLE; held in IDLE until next accept.
REQ-022 busy = 1 in LOAD and DRAIN, 0 in IDLE.
REQ-023 Counters SHALL be sized to hold 3^MAX_STAGES; no wrap within a frame.

Reset
REQ-024 rst SHALL asynchronously force IDLE, counters 0, core_stages 0, and all outputs 0 except cfg_ready=1.
REQ-025 rst mid-frame SHALL abandon the frame; no do_last emitted for it.

Configuration
REQ-026 Macro FFT3_DROP_CNT_EN: when defined, adds output drop_cnt (16 bits), saturating count of drop pulses, cleared by rst only; when undefined, port and logic absent, drop pulse unchanged.

Structure
REQ-027 Package fft3_pkg SHALL hold state enum, MAX_STAGES default, and a pow3 constant table/function (3^0..3^MAX_STAGES).
REQ-028 No sub-module; single flat module.

Verification
REQ-029 cfg_stages=1, 3 di_en samples (1,2,3), core echo delay 4 -> core_en 3 cycles after 1-cycle lag, do_last on 3rd output, busy falls same cycle.
REQ-030 cfg_stages=5, 243 samples back-to-back -> exactly 243 core_en, do_last on output 243, core_stages=5 throughout.
REQ-031 cfg_stages=6 and 0 in IDLE -> err_cfg pulse each, cfg_ready stays 1, core_stages unchanged.
REQ-032 cfg accept with di_en same cycle, then 10 di_en in DRAIN -> 11 drop pulses; with FFT3_DROP_CNT_EN drop_cnt=11.
REQ-033 rst asserted after 5 of 9 samples (stages=2) -> immediate IDLE, busy=0, core_stages=0; next cfg_stages=2 frame completes with 9 outputs.

Source files
------------

// File: rtl/fft3_pkg.sv
// Shared types and constants for the radix-3 FFT frame controller.
package fft3_pkg;

  localparam int MAX_STAGES_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } fft3_state_e;

  // 3^n; evaluated at elaboration for counter sizing and per stage-count lookup.
  function automatic int unsigned pow3(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned k = 0; k < n; k++) r = r * 3;
    return r;
  endfunction

endpackage

// File: rtl/fft3_frame_ctrl.sv
// Frame controller for a 3^stages-point FFT core: accepts a stage count, forwards one frame
// in and one frame out. Optional macro FFT3_DROP_CNT_EN adds a saturating drop counter.
module fft3_frame_ctrl
  import fft3_pkg::*;
#(
  parameter int WIDTH      = 18,
  parameter int MAX_STAGES = MAX_STAGES_DEF,
  parameter int SW         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [SW-1:0]    cfg_stages,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             core_en,
  output logic [WIDTH-1:0] core_re,
  output logic [WIDTH-1:0] core_im,
  output logic [SW-1:0]    core_stages,
  input  logic             cd_en,
  input  logic [WIDTH-1:0] cd_re,
  input  logic [WIDTH-1:0] cd_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic             do_last,
  output logic             busy,
  output logic             err_cfg,
  output logic             drop
`ifdef FFT3_DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int unsigned N_MAX = pow3(MAX_STAGES);
  localparam int CW = $clog2(N_MAX + 1);

  fft3_state_e      state_q, state_d;
  logic [CW-1:0]    in_cnt_q, in_cnt_d;
  logic [CW-1:0]    out_cnt_q, out_cnt_d;
  logic [SW-1:0]    stages_q, stages_d;
  logic             core_en_q, core_en_d;
  logic [WIDTH-1:0] core_re_q, core_re_d, core_im_q, core_im_d;
  logic             do_en_q, do_en_d, do_last_q, do_last_d;
  logic [WIDTH-1:0] do_re_q, do_re_d, do_im_q, do_im_d;
  logic             err_q, err_d, drop_q, drop_d;
  logic [CW-1:0]    n_frame;
  logic             cfg_ok, in_fire, out_fire;

  always_comb begin
    n_frame = '0;
    for (int k = 0; k <= MAX_STAGES; k++) begin
      if (stages_q == SW'(k)) n_frame = CW'(pow3(unsigned'(k)));
    end
  end

  assign cfg_ok   = (cfg_stages != '0) && (cfg_stages <= SW'(MAX_STAGES));
  assign in_fire  = di_en && (state_q == ST_LOAD);
  assign out_fire = cd_en && (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    stages_d  = stages_q;
    core_en_d = 1'b0;
    core_re_d = core_re_q;
    core_im_d = core_im_q;
    do_en_d   = 1'b0;
    do_last_d = 1'b0;
    do_re_d   = do_re_q;
    do_im_d   = do_im_q;
    err_d     = 1'b0;
    drop_d    = di_en && !in_fire;

    if (state_q == ST_IDLE && cfg_valid) begin
      if (cfg_ok) begin
        stages_d  = cfg_stages;
        in_cnt_d  = '0;
        out_cnt_d = '0;
        state_d   = ST_LOAD;
      end else begin
        err_d = 1'b1;
      end
    end

    if (in_fire) begin
      core_en_d = 1'b1;
      core_re_d = di_re;
      core_im_d = di_im;
      in_cnt_d  = in_cnt_q + 1'b1;
      if (in_cnt_q + 1'b1 == n_frame) state_d = ST_DRAIN;
    end

    // Output completion wins: a short-latency core can finish while inputs are still counted.
    if (out_fire) begin
      do_en_d   = 1'b1;
      do_re_d   = cd_re;
      do_im_d   = cd_im;
      out_cnt_d = out_cnt_q + 1'b1;
      if (out_cnt_q + 1'b1 == n_frame) begin
        do_last_d = 1'b1;
        state_d   = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      stages_q  <= '0;
      core_en_q <= 1'b0;
      core_re_q <= '0;
      core_im_q <= '0;
      do_en_q   <= 1'b0;
      do_last_q <= 1'b0;
      do_re_q   <= '0;
      do_im_q   <= '0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      stages_q  <= stages_d;
      core_en_q <= core_en_d;
      core_re_q <= core_re_d;
      core_im_q <= core_im_d;
      do_en_q   <= do_en_d;
      do_last_q <= do_last_d;
      do_re_q   <= do_re_d;
      do_im_q   <= do_im_d;
      err_q     <= err_d;
      drop_q    <= drop_d;
    end
  end

`ifdef FFT3_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else if (drop_d && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign cfg_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign core_en     = core_en_q;
  assign core_re     = core_re_q;
  assign core_im     = core_im_q;
  assign core_stages = stages_q;
  assign do_en       = do_en_q;
  assign do_re       = do_re_q;
  assign do_im       = do_im_q;
  assign do_last     = do_last_q;
  assign err_cfg     = err_q;
  assign drop        = drop_q;

endmodule

// File: tb/tb_fft3_frame_ctrl.sv
// Directed bench for fft3_frame_ctrl: per-cycle vector table plus frame-level sequences.
module tb_fft3_frame_ctrl;
  localparam int W = 18;
  localparam int ECHO = 4;

  logic clk = 1'b0;
  logic rst;
  logic cfg_valid, cfg_ready;
  logic [2:0] cfg_stages;
  logic di_en;
  logic [W-1:0] di_re, di_im;
  logic core_en;
  logic [W-1:0] core_re, core_im;
  logic [2:0] core_stages;
  logic cd_en;
  logic [W-1:0] cd_re, cd_im;
  logic do_en, do_last;
  logic [W-1:0] do_re, do_im;
  logic busy, err_cfg, drop;
`ifdef FFT3_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  fft3_frame_ctrl dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_stages(cfg_stages),
    .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .core_en(core_en), .core_re(core_re), .core_im(core_im), .core_stages(core_stages),
    .cd_en(cd_en), .cd_re(cd_re), .cd_im(cd_im),
    .do_en(do_en), .do_re(do_re), .do_im(do_im), .do_last(do_last),
    .busy(busy), .err_cfg(err_cfg), .drop(drop)
`ifdef FFT3_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor/echo state updated once per cycle in tick().
  logic echo_on = 1'b0;
  logic [7:0] h_en;
  logic [W-1:0] h_re [8];
  logic [W-1:0] h_im [8];
  int n_core, n_do, n_last, n_drop, last_idx, n_stg_bad;
  logic last_busy;
  logic [2:0] stg_watch;
  logic [W-1:0] out_re [300];
  logic [W-1:0] out_im [300];

  task automatic mon_clear();
    n_core = 0; n_do = 0; n_last = 0; n_drop = 0; last_idx = 0; n_stg_bad = 0;
    last_busy = 1'b1;
    h_en = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (core_en) n_core++;
    if (drop) n_drop++;
    if (busy && core_stages != stg_watch) n_stg_bad++;
    if (do_en) begin
      if (n_do < 300) begin
        out_re[n_do] = do_re;
        out_im[n_do] = do_im;
      end
      n_do++;
      if (do_last) begin
        n_last++;
        last_idx = n_do;
        last_busy = busy;
      end
    end
    for (int k = 7; k > 0; k--) begin
      h_re[k] = h_re[k-1];
      h_im[k] = h_im[k-1];
    end
    h_en = {h_en[6:0], core_en};
    h_re[0] = core_re;
    h_im[0] = core_im;
    if (echo_on) begin
      cd_en = h_en[ECHO-1];
      cd_re = h_re[ECHO-1];
      cd_im = h_im[ECHO-1];
    end
  endtask

  task automatic wait_last(input int max_cyc);
    for (int k = 0; k < max_cyc && n_last == 0; k++) tick();
  endtask

  task automatic accept(input logic [2:0] s);
    cfg_valid = 1'b1;
    cfg_stages = s;
    tick();
    cfg_valid = 1'b0;
  endtask

  typedef struct {
    logic cv; logic [2:0] cs; logic de; logic [W-1:0] dr; logic ce; logic [W-1:0] cr;
    logic x_rdy, x_err, x_drop, x_busy, x_cen; logic [W-1:0] x_cre; logic [2:0] x_stg;
    logic x_den, x_last; logic [W-1:0] x_dre;
  } vec_t;

  vec_t tbl [14];
  int bad;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //             cv cs de dr ce cr  | rdy err drp bsy cen cre stg den lst dre
    tbl[0]  = '{1, 6, 0, 0, 0, 0,    1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0,    1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 1, 9, 0, 0,    0, 0, 1, 1, 0, 0, 1, 0, 0, 0};
    tbl[4]  = '{1, 6, 1, 1, 0, 0,    0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 1, 2, 0, 0,    0, 0, 0, 1, 1, 2, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 1, 3, 0, 0,    0, 0, 0, 1, 1, 3, 1, 0, 0, 0};
    tbl[7]  = '{0, 0, 1, 4, 0, 0,    0, 0, 1, 1, 0, 3, 1, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0, 3, 1, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 1, 11,   0, 0, 0, 1, 0, 3, 1, 1, 0, 11};
    tbl[10] = '{0, 0, 0, 0, 1, 12,   0, 0, 0, 1, 0, 3, 1, 1, 0, 12};
    tbl[11] = '{0, 0, 0, 0, 1, 13,   1, 0, 0, 0, 0, 3, 1, 1, 1, 13};
    tbl[12] = '{0, 0, 0, 0, 1, 14,   1, 0, 0, 0, 0, 3, 1, 0, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 0, 0,    1, 1, 0, 0, 0, 3, 1, 0, 0, 0};

    rst = 1'b1;
    cfg_valid = 1'b0; cfg_stages = '0;
    di_en = 1'b0; di_re = '0; di_im = '0;
    cd_en = 1'b0; cd_re = '0; cd_im = '0;
    stg_watch = '0;
    mon_clear();
    repeat (3) tick();

    chk("rst.cfg_ready", cfg_ready, 1);
    chk("rst.busy", busy, 0);
    chk("rst.core_en", core_en, 0);
    chk("rst.core_stages", core_stages, 0);
    chk("rst.do_en", do_en, 0);
    chk("rst.do_last", do_last, 0);
    chk("rst.err_cfg", err_cfg, 0);
    chk("rst.drop", drop, 0);
`ifdef FFT3_DROP_CNT_EN
    chk("rst.drop_cnt", drop_cnt, 0);
`endif
    rst = 1'b0;
    tick();

    // Per-cycle vector table, echo off.
    for (int i = 0; i < 14; i++) begin
      cfg_valid = tbl[i].cv; cfg_stages = tbl[i].cs;
      di_en = tbl[i].de; di_re = tbl[i].dr; di_im = tbl[i].dr + 18'd100;
      cd_en = tbl[i].ce; cd_re = tbl[i].cr; cd_im = tbl[i].cr;
      tick();
      $display("vec %0d: rdy=%0d err=%0d drop=%0d busy=%0d cen=%0d cre=%0d stg=%0d den=%0d last=%0d",
               i, cfg_ready, err_cfg, drop, busy, core_en, core_re, core_stages, do_en, do_last);
      chk($sformatf("row%0d.cfg_ready", i), cfg_ready, tbl[i].x_rdy);
      chk($sformatf("row%0d.err_cfg", i), err_cfg, tbl[i].x_err);
      chk($sformatf("row%0d.drop", i), drop, tbl[i].x_drop);
      chk($sformatf("row%0d.busy", i), busy, tbl[i].x_busy);
      chk($sformatf("row%0d.core_en", i), core_en, tbl[i].x_cen);
      chk($sformatf("row%0d.core_re", i), core_re, tbl[i].x_cre);
      chk($sformatf("row%0d.core_stages", i), core_stages, tbl[i].x_stg);
      chk($sformatf("row%0d.do_en", i), do_en, tbl[i].x_den);
      chk($sformatf("row%0d.do_last", i), do_last, tbl[i].x_last);
      if (tbl[i].x_den) chk($sformatf("row%0d.do_re", i), do_re, tbl[i].x_dre);
    end
    cfg_valid = 1'b0; di_en = 1'b0; cd_en = 1'b0;
    tick();

    // Three-sample frame through an echo core with delay ECHO.
    echo_on = 1'b1;
    stg_watch = 3'd1;
    mon_clear();
    accept(3'd1);
    for (int i = 1; i <= 3; i++) begin
      di_en = 1'b1; di_re = W'(i); di_im = W'(i + 50);
      tick();
      chk($sformatf("s1.core_en%0d", i), core_en, 1);
      chk($sformatf("s1.core_re%0d", i), core_re, i);
    end
    di_en = 1'b0;
    wait_last(40);
    $display("frame s1: core_en=%0d outputs=%0d last_at=%0d", n_core, n_do, last_idx);
    chk("s1.n_core", n_core, 3);
    chk("s1.n_do", n_do, 3);
    chk("s1.n_last", n_last, 1);
    chk("s1.last_idx", last_idx, 3);
    chk("s1.busy_at_last", last_busy, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("s1.do_re%0d", i), out_re[i], i + 1);
      chk($sformatf("s1.do_im%0d", i), out_im[i], i + 51);
    end

    // Full 243-point frame, back-to-back samples.
    stg_watch = 3'd5;
    mon_clear();
    accept(3'd5);
    for (int i = 0; i < 243; i++) begin
      di_en = 1'b1; di_re = W'(i + 1); di_im = W'(i + 1000);
      tick();
    end
    di_en = 1'b0;
    wait_last(40);
    bad = 0;
    for (int i = 0; i < 243; i++) begin
      if (out_re[i] !== W'(i + 1) || out_im[i] !== W'(i + 1000)) bad++;
    end
    $display("frame s5: core_en=%0d outputs=%0d last_at=%0d data_err=%0d", n_core, n_do, last_idx, bad);
    chk("s5.n_core", n_core, 243);
    chk("s5.n_do", n_do, 243);
    chk("s5.n_last", n_last, 1);
    chk("s5.last_idx", last_idx, 243);
    chk("s5.busy_at_last", last_busy, 0);
    chk("s5.stages_stable", n_stg_bad, 0);
    chk("s5.data", bad, 0);
    chk("s5.stages_held", core_stages, 5);
    cfg_valid = 1'b1; cfg_stages = 3'd6;
    tick();
    cfg_valid = 1'b0;
    chk("s5.err6", err_cfg, 1);
    chk("s5.err6_stages", core_stages, 5);
    chk("s5.err6_ready", cfg_ready, 1);

    // Drop accounting: accept cycle plus ten samples while draining.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    echo_on = 1'b0; cd_en = 1'b0;
    stg_watch = 3'd1;
    mon_clear();
    di_en = 1'b1; di_re = 18'd77;
    accept(3'd1);
    for (int i = 0; i < 13; i++) begin
      di_re = W'(i + 1);
      tick();
    end
    di_en = 1'b0;
    tick();
    $display("drop test: drops=%0d core_en=%0d busy=%0d", n_drop, n_core, busy);
    chk("drp.n_drop", n_drop, 11);
    chk("drp.n_core", n_core, 3);
    chk("drp.busy", busy, 1);
`ifdef FFT3_DROP_CNT_EN
    chk("drp.drop_cnt", drop_cnt, 11);
`endif
    for (int i = 0; i < 3; i++) begin
      cd_en = 1'b1; cd_re = W'(i);
      tick();
    end
    cd_en = 1'b0;
    tick();
    chk("drp.n_last", n_last, 1);
    chk("drp.busy_end", busy, 0);

    // Mid-frame reset, then a clean nine-sample frame.
    echo_on = 1'b1;
    stg_watch = 3'd2;
    mon_clear();
    accept(3'd2);
    for (int i = 0; i < 5; i++) begin
      di_en = 1'b1; di_re = W'(i + 1);
      tick();
    end
    di_en = 1'b0;
    rst = 1'b1;
    #1;
    $display("mid reset: busy=%0d stages=%0d ready=%0d core_en=%0d", busy, core_stages, cfg_ready, core_en);
    chk("mrst.busy", busy, 0);
    chk("mrst.core_stages", core_stages, 0);
    chk("mrst.cfg_ready", cfg_ready, 1);
    chk("mrst.core_en", core_en, 0);
    chk("mrst.no_last", n_last, 0);
    echo_on = 1'b0; cd_en = 1'b0;
    tick();
    rst = 1'b0;
    mon_clear();
    echo_on = 1'b1;
    accept(3'd2);
    for (int i = 0; i < 9; i++) begin
      di_en = 1'b1; di_re = W'(i + 20);
      tick();
    end
    di_en = 1'b0;
    wait_last(40);
    $display("frame s2: core_en=%0d outputs=%0d last_at=%0d", n_core, n_do, last_idx);
    chk("s2.n_core", n_core, 9);
    chk("s2.n_do", n_do, 9);
    chk("s2.last_idx", last_idx, 9);
    chk("s2.n_last", n_last, 1);
    chk("s2.last_val", out_re[8], 28);
    repeat (ECHO + 2) tick();
    chk("s2.no_extra", n_do, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
